button_debounce: RTL



---
 rtl/button_debounce_pkg.sv | 27 ++
 rtl/button_debounce_if.sv | 38 +++
 rtl/button_debounce_bit.sv | 86 ++++++++
 rtl/button_debounce.sv | 58 +++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared constants and helpers for the push-button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Four board keys feed the button PIO.
    localparam int BTN_WIDTH_DEF         = 4;
    // 10 ms stability window at a 50 MHz system clock.
    localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
    // Board keys pull low when pressed.
    localparam int BTN_ACTIVE_LOW_DEF    = 1;

    // Ceiling log2; sizes the stability counter so it can hold n-1.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_if
// Description : Raw key pins in, debounced level and edge pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_debounce_if
    import button_pkg::*;
#(
    parameter int WIDTH = BTN_WIDTH_DEF
);

    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_press;
    logic [WIDTH-1:0] btn_release;
    logic             btn_event;

    // Board / consumer side: drives the pins, observes the clean outputs.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_event
    );

    // Debouncer side.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_event
    );

endinterface : button_debounce_if
`default_nettype wire

// File: rtl/button_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : One key channel: 2-flop synchroniser, stability counter,
//               debounced level and registered press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import button_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int ACTIVE_LOW    = BTN_ACTIVE_LOW_DEF
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_raw,
    output logic      o_level,
    output logic      o_press,
    output logic      o_release,
    output logic      o_accept
);

    localparam int               CNT_W      = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    // Pin level of a released key; also the XOR mask that normalises to 1 = pressed.
    localparam logic             C_IDLE     = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    logic w_p;
    logic w_differ;
    logic w_accept;

    assign w_p      = r_s2 ^ C_IDLE;
    assign w_differ = (w_p != r_level);
    // The counter saturates here: the accept edge clears it instead of wrapping.
    assign w_accept = w_differ && (r_cnt == C_CNT_LAST);

    // Two-flop synchroniser; resets to the idle pin level so no press is seen after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= C_IDLE;
            r_s2 <= C_IDLE;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Stability counter, level update and one-cycle edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_differ) begin
                // Any sample agreeing with the current level restarts the window.
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level   <= w_p;
                r_cnt     <= '0;
                r_press   <= w_p;
                r_release <= !w_p;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    // Combinational accept strobe so the top can register btn_event on the same edge as the pulses.
    assign o_accept  = w_accept;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : WIDTH independent key debouncers feeding the button PIO,
//               with a registered any-edge event flag.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import button_pkg::*;
#(
    parameter int WIDTH         = BTN_WIDTH_DEF,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int ACTIVE_LOW    = BTN_ACTIVE_LOW_DEF
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    button_debounce_if.slave  bus
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_release;
    logic [WIDTH-1:0] w_accept;
    logic             r_event;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            debounce_bit #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .ACTIVE_LOW    (ACTIVE_LOW)
            ) u_bit (
                .clk       (clk),
                .reset_n   (reset_n),
                .i_raw     (bus.btn_raw[i]),
                .o_level   (w_level[i]),
                .o_press   (w_press[i]),
                .o_release (w_release[i]),
                .o_accept  (w_accept[i])
            );
        end
    endgenerate

    // Event flag registered from the accept strobes so it lines up with the pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_event <= 1'b0;
        end else begin
            r_event <= |w_accept;
        end
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.btn_event   = r_event;

endmodule : button_debounce
`default_nettype wire
